// File: rtl/lsu_mem_initiator_pkg.sv
// Shared memory size encodings, FSM state type and access-shape helpers for the LSU initiator.
package lsu_mem_initiator_pkg;

   localparam logic [2:0] MEM_BYTE = 3'b000;
   localparam logic [2:0] MEM_HALF = 3'b001;
   localparam logic [2:0] MEM_WORD = 3'b010;
   localparam logic [2:0] MEM_LBU  = 3'b100;
   localparam logic [2:0] MEM_LHU  = 3'b101;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_e;

   // Unused codes collapse to a word; stores never carry the unsigned-load bit.
   function automatic logic [2:0] norm_size(input logic [2:0] code, input logic store);
      logic [2:0] s;
      s = code;
      if (code == 3'd3 || code == 3'd6 || code == 3'd7) s = MEM_WORD;
      if (store) s = s & 3'b011;
      return s;
   endfunction

   // Index of the final beat: 0 for an aligned access, byte count minus one otherwise.
   function automatic logic [1:0] last_beat(input logic [2:0] size, input logic [1:0] addr_lo);
      logic [1:0] l;
      l = 2'd0;
      if (size[1:0] == 2'b01 && addr_lo[0]) l = 2'd1;
      if (size[1:0] == 2'b10 && addr_lo != 2'b00) l = 2'd3;
      return l;
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of an assembled load word according to its funct3 size code.
module lsu_load_extend
   import lsu_mem_initiator_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  size,
   output logic [31:0] result
);

   always_comb begin
      result = word;
      case (size)
         MEM_BYTE: result = {{24{word[7]}}, word[7:0]};
         MEM_HALF: result = {{16{word[15]}}, word[15:0]};
         MEM_LBU:  result = {24'h0, word[7:0]};
         MEM_LHU:  result = {16'h0, word[15:0]};
         default:  result = word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request per handshake, misaligned accesses split into byte beats.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned requests with resp_err_o.
module lsu_mem_initiator
   import lsu_mem_initiator_pkg::*;
#(
   parameter int unsigned          AWIDTH    = 32,
   parameter int unsigned          DWIDTH    = 32,
   parameter logic [AWIDTH-1:0]    BASE_ADDR = 'h01000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [AWIDTH-1:0] req_addr_i,
   input  logic [DWIDTH-1:0] req_data_i,
   input  logic [2:0]        req_size_encoded_i,
   input  logic              req_store_i,
   output logic              resp_valid_o,
   output logic [DWIDTH-1:0] resp_data_o,
   output logic              resp_err_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic [2:0]        mem_size_encoded_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   input  logic [DWIDTH-1:0] mem_data_i
);

   lsu_state_e        state;
   logic [AWIDTH-1:0] base;
   logic [DWIDTH-1:0] wdata;
   logic [DWIDTH-1:0] asm_word;
   logic [2:0]        size;
   logic              store;
   logic              split;
   logic [1:0]        beat;
   logic [1:0]        last;

   logic [2:0]        acc_size;
   logic [1:0]        acc_last;
   logic [1:0]        beat_nxt;
   logic [DWIDTH-1:0] asm_next;
   logic [DWIDTH-1:0] ext_word;

   assign acc_size = norm_size(req_size_encoded_i, req_store_i);
   assign acc_last = last_beat(acc_size, req_addr_i[1:0]);
   assign beat_nxt = beat + 2'd1;

   // Assembly including the byte arriving this cycle, so the final beat extends in one step.
   always_comb begin
      asm_next = asm_word;
      asm_next[{beat, 3'b000} +: 8] = mem_data_i[7:0];
   end

   lsu_load_extend u_extend (
      .word   (asm_next),
      .size   (size),
      .result (ext_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         req_ready_o        <= 1'b1;
         resp_valid_o       <= 1'b0;
         resp_data_o        <= '0;
         resp_err_o         <= 1'b0;
         mem_read_en_o      <= 1'b0;
         mem_write_en_o     <= 1'b0;
         mem_addr_o         <= BASE_ADDR;
         mem_data_o         <= '0;
         mem_size_encoded_o <= MEM_WORD;
         beat               <= 2'd0;
         last               <= 2'd0;
         asm_word           <= '0;
         base               <= '0;
         wdata              <= '0;
         size               <= MEM_WORD;
         store              <= 1'b0;
         split              <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid_o <= 1'b0;
               if (req_valid_i) begin
                  req_ready_o <= 1'b0;
                  base        <= req_addr_i;
                  wdata       <= req_data_i;
                  size        <= acc_size;
                  store       <= req_store_i;
                  split       <= (acc_last != 2'd0);
                  last        <= acc_last;
                  beat        <= 2'd0;
                  asm_word    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                  if (acc_last != 2'd0) begin
                     state        <= RESP;
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                     resp_data_o  <= '0;
                  end else
`endif
                  begin
                     state              <= ACCESS;
                     mem_addr_o         <= req_addr_i;
                     mem_data_o         <= req_data_i;
                     mem_size_encoded_o <= (acc_last != 2'd0) ?
                                           (req_store_i ? MEM_BYTE : MEM_LBU) : acc_size;
                     mem_read_en_o      <= !req_store_i;
                     mem_write_en_o     <= req_store_i;
                  end
               end
            end
            ACCESS: begin
               if (!store) asm_word <= split ? asm_next : mem_data_i;
               if (beat == last) begin
                  state          <= RESP;
                  mem_read_en_o  <= 1'b0;
                  mem_write_en_o <= 1'b0;
                  resp_valid_o   <= 1'b1;
                  resp_err_o     <= 1'b0;
                  // Aligned loads arrive already extended by the memory.
                  resp_data_o    <= store ? '0 : (split ? ext_word : mem_data_i);
               end else begin
                  beat       <= beat_nxt;
                  mem_addr_o <= base + AWIDTH'(beat_nxt);
                  mem_data_o <= wdata >> {beat_nxt, 3'b000};
               end
            end
            RESP: begin
               resp_valid_o <= 1'b0;
               req_ready_o  <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               state          <= IDLE;
               req_ready_o    <= 1'b1;
               mem_read_en_o  <= 1'b0;
               mem_write_en_o <= 1'b0;
               resp_valid_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: byte-array memory, transaction-level model, per-cycle compare.
module tb_lsu_mem_initiator;

   localparam logic [31:0] BASE = 32'h01000000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [2:0]  req_size;
   logic        req_store;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_size;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   lsu_mem_initiator #(
      .AWIDTH    (32),
      .DWIDTH    (32),
      .BASE_ADDR (BASE)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid_i        (req_valid),
      .req_ready_o        (req_ready),
      .req_addr_i         (req_addr),
      .req_data_i         (req_data),
      .req_size_encoded_i (req_size),
      .req_store_i        (req_store),
      .resp_valid_o       (resp_valid),
      .resp_data_o        (resp_data),
      .resp_err_o         (resp_err),
      .mem_addr_o         (mem_addr),
      .mem_data_o         (mem_wdata),
      .mem_size_encoded_o (mem_size),
      .mem_read_en_o      (mem_re),
      .mem_write_en_o     (mem_we),
      .mem_data_i         (mem_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] init_byte(input int i);
      case (i)
         0:       return 8'hEF;
         1:       return 8'hBE;
         2:       return 8'hAD;
         3:       return 8'hDE;
         8'h11:   return 8'h80;
         8'h12:   return 8'hFF;
         default: return 8'(i) ^ 8'h5A;
      endcase
   endfunction

   // Environment memory: 256 bytes, address bits [7:0], extends like the real data memory.
   logic [7:0]  mem [256];
   logic        mem_init;
   logic [7:0]  ra;
   logic [31:0] rw;

   always_comb begin
      ra = mem_addr[7:0];
      rw = {mem[8'(ra + 8'd3)], mem[8'(ra + 8'd2)], mem[8'(ra + 8'd1)], mem[ra]};
      case (mem_size)
         3'b000:  mem_rdata = {{24{rw[7]}}, rw[7:0]};
         3'b001:  mem_rdata = {{16{rw[15]}}, rw[15:0]};
         3'b100:  mem_rdata = {24'h0, rw[7:0]};
         3'b101:  mem_rdata = {16'h0, rw[15:0]};
         default: mem_rdata = rw;
      endcase
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
      end else if (mem_we) begin
         mem[ra] <= mem_wdata[7:0];
         if (mem_size[1:0] != 2'b00) mem[8'(ra + 8'd1)] <= mem_wdata[15:8];
         if (mem_size[1:0] == 2'b10) begin
            mem[8'(ra + 8'd2)] <= mem_wdata[23:16];
            mem[8'(ra + 8'd3)] <= mem_wdata[31:24];
         end
      end
   end

   // Reference model state.
   logic [7:0]  ref_mem [256];
   logic        cmp_en = 1'b0;
   logic        exp_ready, exp_re, exp_we, exp_rvalid, exp_err;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [2:0]  exp_size;
   logic        nxt_store;
   logic [2:0]  nxt_size;
   logic [31:0] nxt_addr, nxt_data;

   function automatic int width_of(input logic [2:0] code);
      case (code)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic logic [2:0] one_beat_code(input logic st, input logic [2:0] code);
      int w;
      w = width_of(code);
      if (st) return (w == 1) ? 3'd0 : ((w == 2) ? 3'd1 : 3'd2);
      if (code == 3'd0 || code == 3'd1 || code == 3'd4 || code == 3'd5) return code;
      return 3'd2;
   endfunction

   function automatic logic [31:0] load_value(input logic [2:0] code, input logic [31:0] addr);
      int          w;
      logic [31:0] v;
      logic        sgn;
      w = width_of(code);
      v = 32'h0;
      for (int i = 0; i < w; i++) v = v | (32'(ref_mem[8'(addr[7:0] + 8'(i))]) << (8 * i));
      sgn = (code == 3'd0 || code == 3'd1);
      if (w == 1 && sgn && v[7]) v = v | 32'hFFFFFF00;
      if (w == 2 && sgn && v[15]) v = v | 32'hFFFF0000;
      return v;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp("req_ready", 32'(req_ready), 32'(exp_ready));
         cmp("mem_read_en", 32'(mem_re), 32'(exp_re));
         cmp("mem_write_en", 32'(mem_we), 32'(exp_we));
         cmp("resp_valid", 32'(resp_valid), 32'(exp_rvalid));
         cmp("resp_data", resp_data, exp_rdata);
         if (exp_re || exp_we) begin
            cmp("mem_addr", mem_addr, exp_addr);
            cmp("mem_size", 32'(mem_size), 32'(exp_size));
         end
         if (exp_we) cmp("mem_wdata", mem_wdata, exp_wdata);
         if (exp_rvalid) cmp("resp_err", 32'(resp_err), 32'(exp_err));
      end
   end

   task automatic idle_expect();
      exp_ready  = 1'b1;
      exp_re     = 1'b0;
      exp_we     = 1'b0;
      exp_rvalid = 1'b0;
   endtask

   // Runs one request from IDLE; hold_next presents nxt_* during the response cycle.
   task automatic run_txn(input logic st, input logic [2:0] code, input logic [31:0] addr,
                          input logic [31:0] data, input logic hold_next);
      int          w, n;
      logic        aligned, err;
      logic [31:0] res;
      w       = width_of(code);
      aligned = (w == 1) || (w == 2 && !addr[0]) || (w == 4 && addr[1:0] == 2'b00);
      n       = aligned ? 1 : w;
      err     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (!aligned) begin
         n   = 0;
         err = 1'b1;
      end
`endif
      res = (st || err) ? 32'h0 : load_value(code, addr);
      req_valid = 1'b1;
      req_store = st;
      req_size  = code;
      req_addr  = addr;
      req_data  = data;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         exp_ready = 1'b0;
         exp_re    = !st;
         exp_we    = st;
         exp_addr  = addr + 32'(k);
         exp_size  = aligned ? one_beat_code(st, code) : (st ? 3'd0 : 3'd4);
         exp_wdata = data >> (8 * k);
         if (st && aligned) begin
            for (int i = 0; i < w; i++) ref_mem[8'(addr[7:0] + 8'(i))] = 8'(data >> (8 * i));
         end else if (st) begin
            ref_mem[8'(addr[7:0] + 8'(k))] = 8'(data >> (8 * k));
         end
         @(posedge clk); #1;
      end
      exp_ready  = 1'b0;
      exp_re     = 1'b0;
      exp_we     = 1'b0;
      exp_rvalid = 1'b1;
      exp_rdata  = res;
      exp_err    = err;
      if (hold_next) begin
         req_valid = 1'b1;
         req_store = nxt_store;
         req_size  = nxt_size;
         req_addr  = nxt_addr;
         req_data  = nxt_data;
      end
      @(posedge clk); #1;
      idle_expect();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
      rst       = 1'b1;
      mem_init  = 1'b1;
      req_valid = 1'b0;
      req_store = 1'b0;
      req_size  = 3'd0;
      req_addr  = 32'h0;
      req_data  = 32'h0;
      idle_expect();
      exp_rdata = 32'h0;
      exp_err   = 1'b0;
      exp_addr  = BASE;
      exp_size  = 3'd2;
      exp_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      cmp("reset_mem_addr", mem_addr, BASE);
      cmp("reset_mem_size", 32'(mem_size), 32'h2);
      cmp("reset_mem_wdata", mem_wdata, 32'h0);
      cmp("reset_resp_err", 32'(resp_err), 32'h0);
      @(posedge clk); #1;
      rst      = 1'b0;
      mem_init = 1'b0;
      @(posedge clk); #1;

      run_txn(1'b0, 3'd2, BASE, 32'h0, 1'b0);
      cmp("lw_literal", resp_data, 32'hDEADBEEF);

      run_txn(1'b1, 3'd2, BASE + 32'h2, 32'h11223344, 1'b0);
      cmp("sw_resp_zero", resp_data, 32'h0);
      cmp("sw_byte2", 32'(mem[2]), 32'h44);
      cmp("sw_byte3", 32'(mem[3]), 32'h33);
      cmp("sw_byte4", 32'(mem[4]), 32'h22);
      cmp("sw_byte5", 32'(mem[5]), 32'h11);

      // LHU presented during the LH response must be ignored, then taken in IDLE.
      nxt_store = 1'b0;
      nxt_size  = 3'd5;
      nxt_addr  = BASE + 32'h11;
      nxt_data  = 32'h0;
      run_txn(1'b0, 3'd1, BASE + 32'h11, 32'h0, 1'b1);
      cmp("lh_literal", resp_data, 32'hFFFFFF80);
      run_txn(1'b0, 3'd5, BASE + 32'h11, 32'h0, 1'b0);
      cmp("lhu_literal", resp_data, 32'h0000FF80);

      run_txn(1'b0, 3'd0, BASE + 32'h90, 32'h0, 1'b0);
      cmp("lb_literal", resp_data, 32'hFFFFFFCA);
      run_txn(1'b0, 3'd4, BASE + 32'h90, 32'h0, 1'b0);
      run_txn(1'b1, 3'd1, BASE + 32'h20, 32'hAAAA_8123, 1'b0);
      run_txn(1'b0, 3'd1, BASE + 32'h20, 32'h0, 1'b0);
      run_txn(1'b1, 3'd4, BASE + 32'h31, 32'h0000_00F7, 1'b0);
      run_txn(1'b0, 3'd0, BASE + 32'h31, 32'h0, 1'b0);
      run_txn(1'b1, 3'd2, BASE + 32'h24, 32'hCAFE_BABE, 1'b0);
      run_txn(1'b0, 3'd3, BASE + 32'h24, 32'h0, 1'b0);
      run_txn(1'b0, 3'd2, BASE + 32'h1, 32'h0, 1'b0);
      run_txn(1'b0, 3'd7, BASE + 32'h26, 32'h0, 1'b0);
      run_txn(1'b1, 3'd6, BASE + 32'h51, 32'h1357_9BDF, 1'b0);
      run_txn(1'b1, 3'd5, BASE + 32'h63, 32'h0000_A55A, 1'b0);
      run_txn(1'b0, 3'd5, BASE + 32'h63, 32'h0, 1'b0);
      run_txn(1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);

      // Reset lands at the edge ending the second beat of a split store.
      req_valid = 1'b1;
      req_store = 1'b1;
      req_size  = 3'd2;
      req_addr  = BASE + 32'h42;
      req_data  = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      exp_ready  = 1'b0;
      exp_rvalid = 1'b1;
      exp_rdata  = 32'h0;
      exp_err    = 1'b1;
      @(posedge clk); #1;
      idle_expect();
      @(posedge clk); #1;
`else
      for (int k = 0; k < 2; k++) begin
         exp_ready = 1'b0;
         exp_we    = 1'b1;
         exp_addr  = BASE + 32'h42 + 32'(k);
         exp_size  = 3'd0;
         exp_wdata = 32'hCAFE_F00D >> (8 * k);
         ref_mem[8'h42 + k] = 8'(32'hCAFE_F00D >> (8 * k));
         if (k == 1) rst = 1'b1;
         @(posedge clk); #1;
      end
      rst = 1'b0;
      idle_expect();
      exp_rdata = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cmp("rst_byte0", 32'(mem[8'h42]), 32'h0D);
      cmp("rst_byte1", 32'(mem[8'h43]), 32'hF0);
      cmp("rst_byte2", 32'(mem[8'h44]), 32'h1E);
      cmp("rst_byte3", 32'(mem[8'h45]), 32'h1F);
`endif

      run_txn(1'b0, 3'd2, BASE + 32'h40, 32'h0, 1'b0);

      for (int i = 0; i < 256; i++) cmp($sformatf("mem_%0h", i), 32'(mem[i]), 32'(ref_mem[i]));

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
